reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 The block SHALL have parameter ROB_SIZE, default 16, number of entries; ROB ids are 1..ROB_SIZE and id 0 (ZERO_ROB) means "no producer".
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  in  1  clock, all state on rising edge.
REQ-004 Port: rst  in  1  asynchronous active-low reset (0 = reset).
REQ-005 Port: rdy  in  1  global enable; 0 freezes all state.
REQ-006 Port: alloc_signal_from_dispatcher  in  1  allocate one entry this cycle.
REQ-007 Port: rd_from_dispatcher  in  5  destination register of allocated instruction.
REQ-008 Port: pc_from_dispatcher  in  32  instruction PC.
REQ-009 Port: is_branch_from_dispatcher / predicted_jump_from_dispatcher  in  1 each  branch flag and predicted direction.
REQ-010 Port: rob_id_to_dispatcher  out  5  id the next allocation receives (tail index + 1).
REQ-011 Port: rob_full  out  1  no free entry; dispatcher SHALL NOT allocate.
REQ-012 Port: Q1_from_dispatcher / Q2_from_dispatcher  in  5 each  operand producer ids to look up.
REQ-013 Port: ready1_to_dispatcher / ready2_to_dispatcher  out  1 each; V1_to_dispatcher / V2_to_dispatcher  out  32 each  lookup results.
REQ-014 Port: cdb_valid  in  1; cdb_rob_id  in  5; cdb_value  in  32; cdb_jump  in  1 (actual taken); cdb_target_pc  in  32  execution result broadcast.
REQ-015 Port: commit_flag  out  1  one-cycle commit pulse to register file.
REQ-016 Port: rd_to_reg  out  5; Q_to_reg  out  5 (committing id); V_to_reg  out  32.
REQ-017 Port: rollback_flag  out  1  mispredict flush pulse; target_pc  out  32  redirect PC.

Function
REQ-018 Storage SHALL be a circular buffer: head, tail (log2 ROB_SIZE bits, wrap ROB_SIZE-1 -> 0) and count (0..ROB_SIZE); per entry: busy, ready, rd, pc, is_branch, pred_jump, value, actual_jump, target.
REQ-019 rob_full SHALL be combinational: count == ROB_SIZE.
REQ-020 Allocation SHALL occur when alloc_signal_from_dispatcher && !rob_full: entry[tail] busy=1, ready=0, fields captured; tail++; an allocation request while full SHALL be ignored.
REQ-021 On cdb_valid with cdb_rob_id != 0 and entry busy, entry[id-1] SHALL set ready=1 and capture value, actual_jump, target; a write to a non-busy entry or id 0 SHALL be ignored.
REQ-022 Lookup SHALL be combinational: Qx == 0 -> ready=1, V=0; matching same-cycle CDB -> ready=1, V=cdb_value; else entry ready/value.
REQ-023 Commit: when count>0 and entry[head] ready (registered state), next edge SHALL drive commit_flag=1, rd_to_reg=rd, Q_to_reg=head+1, V_to_reg=value, clear busy, head++; otherwise commit_flag=0.
REQ-024 At most one commit per cycle; in-order only; a CDB write to the head entry is committable no earlier than the following cycle.
REQ-025 Simultaneous allocate and commit SHALL leave count unchanged.
REQ-026 Committing branch with actual_jump != pred_jump SHALL, in the same edge as commit_flag, set rollback_flag=1 and target_pc = actual_jump ? target : pc+4 (mod 2^32).
REQ-027 On that mispredict edge all entries SHALL be cleared and head=tail=count=0; any same-cycle allocation or CDB write SHALL be discarded.
REQ-028 Correctly predicted branches SHALL commit with rollback_flag=0.
REQ-029 commit_flag and rollback_flag SHALL be single-cycle pulses.
REQ-030 rdy=0 SHALL hold all state and force commit_flag=0, rollback_flag=0 on that edge.

Reset
REQ-031 rst=0 SHALL immediately clear head, tail, count, all busy/ready bits; commit_flag=0, rollback_flag=0, rd_to_reg=0, Q_to_reg=0, V_to_reg=0, target_pc=0; rob_id_to_dispatcher=1; rob_full=0.
REQ-032 Reset asserted mid-commit or mid-rollback SHALL abort it with no further pulse after release.

Verification
REQ-033 Allocate rd=5 (id 1), CDB id1 value 0x1234 -> next edge commit_flag=1, rd_to_reg=5, Q_to_reg=1, V_to_reg=0x1234.
REQ-034 Allocate 16 with no CDB -> rob_full=1, 17th alloc ignored; CDB id1 -> commit, rob_full=0, next allocation gets id 1 (wrap).
REQ-035 CDB ids 3,2 before 1 -> commits strictly ids 1,2,3 on consecutive cycles.
REQ-036 Branch pc=0x100 pred_jump=1, CDB cdb_jump=0 -> commit with rollback_flag=1, target_pc=0x104; next cycle count=0, rob_id_to_dispatcher=1.
REQ-037 Lookup Q1=4 while cdb_valid id4 value 0xAB -> ready1=1, V1=0xAB same cycle; Q2=0 -> ready2=1, V2=0.
REQ-038 rdy=0 for 3 cycles with ready head -> no commit pulse; rdy=1 -> commit next edge; rst=0 mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// -----------------------------------------------------------------------------
// reorder_buffer_if
// Groups the reorder buffer's three traffic groups into one bundle:
//   dispatcher : allocation request/fields, next id, full flag, operand lookups
//   cdb        : execution result broadcast (value, branch outcome, target)
//   commit     : register-file write pulse and mispredict redirect
// modport master : the side that dispatches/broadcasts and observes commits
// modport slave  : the reorder buffer itself
// -----------------------------------------------------------------------------
interface reorder_buffer_if;
    // dispatcher group
    logic        alloc_signal_from_dispatcher;
    logic [4:0]  rd_from_dispatcher;
    logic [31:0] pc_from_dispatcher;
    logic        is_branch_from_dispatcher;
    logic        predicted_jump_from_dispatcher;
    logic [4:0]  rob_id_to_dispatcher;
    logic        rob_full;
    logic [4:0]  Q1_from_dispatcher;
    logic [4:0]  Q2_from_dispatcher;
    logic        ready1_to_dispatcher;
    logic        ready2_to_dispatcher;
    logic [31:0] V1_to_dispatcher;
    logic [31:0] V2_to_dispatcher;
    // common data bus group
    logic        cdb_valid;
    logic [4:0]  cdb_rob_id;
    logic [31:0] cdb_value;
    logic        cdb_jump;
    logic [31:0] cdb_target_pc;
    // commit group
    logic        commit_flag;
    logic [4:0]  rd_to_reg;
    logic [4:0]  Q_to_reg;
    logic [31:0] V_to_reg;
    logic        rollback_flag;
    logic [31:0] target_pc;

    modport master (
        output alloc_signal_from_dispatcher, rd_from_dispatcher, pc_from_dispatcher,
               is_branch_from_dispatcher, predicted_jump_from_dispatcher,
               Q1_from_dispatcher, Q2_from_dispatcher,
               cdb_valid, cdb_rob_id, cdb_value, cdb_jump, cdb_target_pc,
        input  rob_id_to_dispatcher, rob_full,
               ready1_to_dispatcher, ready2_to_dispatcher, V1_to_dispatcher, V2_to_dispatcher,
               commit_flag, rd_to_reg, Q_to_reg, V_to_reg, rollback_flag, target_pc
    );

    modport slave (
        input  alloc_signal_from_dispatcher, rd_from_dispatcher, pc_from_dispatcher,
               is_branch_from_dispatcher, predicted_jump_from_dispatcher,
               Q1_from_dispatcher, Q2_from_dispatcher,
               cdb_valid, cdb_rob_id, cdb_value, cdb_jump, cdb_target_pc,
        output rob_id_to_dispatcher, rob_full,
               ready1_to_dispatcher, ready2_to_dispatcher, V1_to_dispatcher, V2_to_dispatcher,
               commit_flag, rd_to_reg, Q_to_reg, V_to_reg, rollback_flag, target_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// Circular in-order reorder buffer. Entries are allocated at the tail by the
// dispatcher, completed out of order from the CDB, and retired one per cycle
// from the head. A retiring branch whose outcome differs from its prediction
// flushes the whole buffer and redirects fetch.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   rdy  : global enable, 0 freezes all state
//   rob  : reorder_buffer_if.slave (dispatcher, CDB and commit groups)
// ROB ids are 1..ROB_SIZE; id 0 means "no producer".
// -----------------------------------------------------------------------------
module reorder_buffer #(
    parameter int ROB_SIZE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    reorder_buffer_if.slave  rob
);
    localparam int IDX_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
    localparam int CNT_W = $clog2(ROB_SIZE + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ROB_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROB_SIZE - 1);
    localparam logic [4:0]       MAX_ID   = 5'(ROB_SIZE);

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        is_branch;
        logic        pred_jump;
        logic [31:0] value;
        logic        actual_jump;
        logic [31:0] target;
    } entry_t;

    entry_t            ent_q [ROB_SIZE];
    entry_t            ent_d [ROB_SIZE];
    logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              commit_flag_q, commit_flag_d;
    logic              rollback_flag_q, rollback_flag_d;
    logic [4:0]        rd_to_reg_q, rd_to_reg_d;
    logic [4:0]        q_to_reg_q, q_to_reg_d;
    logic [31:0]       v_to_reg_q, v_to_reg_d;
    logic [31:0]       target_pc_q, target_pc_d;

    entry_t            head_ent_s;
    logic              full_s, alloc_s, commit_s, mispredict_s, cdb_hit_s;
    logic [IDX_W-1:0]  cdb_idx_s;
    logic [32:0]       look1_s, look2_s;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (idx == LAST_IDX) begin
            return '0;
        end else begin
            return idx + IDX_W'(1'b1);
        end
    endfunction

    function automatic logic id_in_range(input logic [4:0] id);
        return (id != 5'd0) && (id <= MAX_ID);
    endfunction

    function automatic logic [IDX_W-1:0] id_to_idx(input logic [4:0] id);
        logic [4:0] m;
        m = id - 5'd1;
        return m[IDX_W-1:0];
    endfunction

    // Operand lookup result {ready, value}: a same-cycle CDB hit bypasses storage
    function automatic logic [32:0] lookup(input logic [4:0] q, input logic cv,
                                           input logic [4:0] cid, input logic [31:0] cval,
                                           input logic e_ready, input logic [31:0] e_value);
        if (q == 5'd0) begin
            return {1'b1, 32'd0};
        end else if (cv && (cid == q)) begin
            return {1'b1, cval};
        end else if (id_in_range(q)) begin
            return {e_ready, e_value};
        end else begin
            return {1'b0, 32'd0};
        end
    endfunction

    assign head_ent_s   = ent_q[head_q];
    assign full_s       = (count_q == FULL_CNT);
    assign alloc_s      = rob.alloc_signal_from_dispatcher && !full_s;
    // Commit uses only registered readiness, so a CDB write to the head retires a cycle later
    assign commit_s     = (count_q != '0) && head_ent_s.ready;
    assign mispredict_s = commit_s && head_ent_s.is_branch &&
                          (head_ent_s.actual_jump != head_ent_s.pred_jump);
    assign cdb_idx_s    = id_to_idx(rob.cdb_rob_id);
    assign cdb_hit_s    = rob.cdb_valid && id_in_range(rob.cdb_rob_id) && ent_q[cdb_idx_s].busy;

    // Combinational operand lookups for the dispatcher
    always_comb begin
        look1_s = lookup(rob.Q1_from_dispatcher, rob.cdb_valid, rob.cdb_rob_id, rob.cdb_value,
                         ent_q[id_to_idx(rob.Q1_from_dispatcher)].ready,
                         ent_q[id_to_idx(rob.Q1_from_dispatcher)].value);
        look2_s = lookup(rob.Q2_from_dispatcher, rob.cdb_valid, rob.cdb_rob_id, rob.cdb_value,
                         ent_q[id_to_idx(rob.Q2_from_dispatcher)].ready,
                         ent_q[id_to_idx(rob.Q2_from_dispatcher)].value);
    end

    // Next-state: commit/rollback first, then CDB completion, head retire, tail allocate
    always_comb begin
        ent_d           = ent_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        commit_flag_d   = 1'b0;
        rollback_flag_d = 1'b0;
        rd_to_reg_d     = rd_to_reg_q;
        q_to_reg_d      = q_to_reg_q;
        v_to_reg_d      = v_to_reg_q;
        target_pc_d     = target_pc_q;
        if (rdy) begin
            if (commit_s) begin
                commit_flag_d = 1'b1;
                rd_to_reg_d   = head_ent_s.rd;
                q_to_reg_d    = 5'(head_q) + 5'd1;
                v_to_reg_d    = head_ent_s.value;
            end else begin
                commit_flag_d = 1'b0;
            end
            if (mispredict_s) begin
                // Flush everything; same-cycle allocation and CDB write are dropped
                rollback_flag_d = 1'b1;
                target_pc_d     = head_ent_s.actual_jump ? head_ent_s.target
                                                         : (head_ent_s.pc + 32'd4);
                for (int i = 0; i < ROB_SIZE; i++) begin
                    ent_d[i] = '0;
                end
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (cdb_hit_s) begin
                    ent_d[cdb_idx_s].ready       = 1'b1;
                    ent_d[cdb_idx_s].value       = rob.cdb_value;
                    ent_d[cdb_idx_s].actual_jump = rob.cdb_jump;
                    ent_d[cdb_idx_s].target      = rob.cdb_target_pc;
                end else begin
                    ent_d[cdb_idx_s] = ent_d[cdb_idx_s];
                end
                if (commit_s) begin
                    ent_d[head_q].busy = 1'b0;
                    head_d             = next_idx(head_q);
                end else begin
                    head_d = head_q;
                end
                if (alloc_s) begin
                    ent_d[tail_q].busy        = 1'b1;
                    ent_d[tail_q].ready       = 1'b0;
                    ent_d[tail_q].rd          = rob.rd_from_dispatcher;
                    ent_d[tail_q].pc          = rob.pc_from_dispatcher;
                    ent_d[tail_q].is_branch   = rob.is_branch_from_dispatcher;
                    ent_d[tail_q].pred_jump   = rob.predicted_jump_from_dispatcher;
                    ent_d[tail_q].value       = 32'd0;
                    ent_d[tail_q].actual_jump = 1'b0;
                    ent_d[tail_q].target      = 32'd0;
                    tail_d                    = next_idx(tail_q);
                end else begin
                    tail_d = tail_q;
                end
                case ({alloc_s, commit_s})
                    2'b10:   count_d = count_q + CNT_W'(1'b1);
                    2'b01:   count_d = count_q - CNT_W'(1'b1);
                    default: count_d = count_q;
                endcase
            end
        end else begin
            commit_flag_d   = 1'b0;
            rollback_flag_d = 1'b0;
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                ent_q[i] <= '0;
            end
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            commit_flag_q   <= 1'b0;
            rollback_flag_q <= 1'b0;
            rd_to_reg_q     <= 5'd0;
            q_to_reg_q      <= 5'd0;
            v_to_reg_q      <= 32'd0;
            target_pc_q     <= 32'd0;
        end else begin
            ent_q           <= ent_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            commit_flag_q   <= commit_flag_d;
            rollback_flag_q <= rollback_flag_d;
            rd_to_reg_q     <= rd_to_reg_d;
            q_to_reg_q      <= q_to_reg_d;
            v_to_reg_q      <= v_to_reg_d;
            target_pc_q     <= target_pc_d;
        end
    end

    assign rob.rob_full             = full_s;
    assign rob.rob_id_to_dispatcher = 5'(tail_q) + 5'd1;
    assign rob.ready1_to_dispatcher = look1_s[32];
    assign rob.V1_to_dispatcher     = look1_s[31:0];
    assign rob.ready2_to_dispatcher = look2_s[32];
    assign rob.V2_to_dispatcher     = look2_s[31:0];
    assign rob.commit_flag          = commit_flag_q;
    assign rob.rd_to_reg            = rd_to_reg_q;
    assign rob.Q_to_reg             = q_to_reg_q;
    assign rob.V_to_reg             = v_to_reg_q;
    assign rob.rollback_flag        = rollback_flag_q;
    assign rob.target_pc            = target_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
// Self-checking bench: directed scenarios plus randomized traffic, compared
// against an in-order queue model of the reorder buffer.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;
    localparam int N = 16;

    logic clk_r = 1'b0;
    logic rst_r;
    logic rdy_r;
    reorder_buffer_if rob_bus ();

    reorder_buffer #(.ROB_SIZE(N)) dut (
        .clk (clk_r),
        .rst (rst_r),
        .rdy (rdy_r),
        .rob (rob_bus)
    );

    always #5 clk_r = ~clk_r;

    typedef struct {
        int          id;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        br;
        logic        pred;
        logic        ready;
        logic [31:0] val;
        logic        jmp;
        logic [31:0] tgt;
    } m_ent_t;

    m_ent_t      mq[$];
    logic        m_ready [32];
    logic [31:0] m_val   [32];
    int          m_next_id;
    logic        e_commit, e_rb;
    logic [4:0]  e_rd, e_q;
    logic [31:0] e_v, e_tpc;
    int          pass_cnt = 0;
    int          chk_cnt  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_next_id = 1;
        for (int i = 0; i < 32; i++) begin
            m_ready[i] = 1'b0;
            m_val[i]   = 32'd0;
        end
    endtask

    task automatic model_reset();
        model_clear();
        e_commit = 1'b0; e_rb = 1'b0; e_rd = 5'd0; e_q = 5'd0; e_v = 32'd0; e_tpc = 32'd0;
    endtask

    // Apply one clock edge of the specified behaviour to the model
    task automatic model_edge();
        bit     was_full;
        bit     do_commit;
        m_ent_t h;
        e_commit = 1'b0;
        e_rb     = 1'b0;
        if (!rdy_r) return;
        was_full  = (mq.size() == N);
        do_commit = (mq.size() > 0) && mq[0].ready;
        if (do_commit) begin
            h        = mq[0];
            e_commit = 1'b1;
            e_rd     = h.rd;
            e_q      = 5'(h.id);
            e_v      = h.val;
            if (h.br && (h.jmp != h.pred)) begin
                e_rb  = 1'b1;
                e_tpc = h.jmp ? h.tgt : h.pc + 32'd4;
                model_clear();
                return;
            end
        end
        if (rob_bus.cdb_valid && rob_bus.cdb_rob_id != 5'd0) begin
            foreach (mq[i]) begin
                if (mq[i].id == int'(rob_bus.cdb_rob_id)) begin
                    mq[i].ready = 1'b1;
                    mq[i].val   = rob_bus.cdb_value;
                    mq[i].jmp   = rob_bus.cdb_jump;
                    mq[i].tgt   = rob_bus.cdb_target_pc;
                    m_ready[mq[i].id] = 1'b1;
                    m_val[mq[i].id]   = rob_bus.cdb_value;
                end
            end
        end
        if (do_commit) void'(mq.pop_front());
        if (rob_bus.alloc_signal_from_dispatcher && !was_full) begin
            h.id = m_next_id; h.rd = rob_bus.rd_from_dispatcher; h.pc = rob_bus.pc_from_dispatcher;
            h.br = rob_bus.is_branch_from_dispatcher; h.pred = rob_bus.predicted_jump_from_dispatcher;
            h.ready = 1'b0; h.val = 32'd0; h.jmp = 1'b0; h.tgt = 32'd0;
            mq.push_back(h);
            m_ready[m_next_id] = 1'b0;
            m_next_id = (m_next_id == N) ? 1 : m_next_id + 1;
        end
    endtask

    task automatic check_lookup(input string tag, input logic [4:0] q, input logic r_obs,
                                input logic [31:0] v_obs);
        logic        r;
        logic [31:0] v;
        if (q == 5'd0) begin
            r = 1'b1; v = 32'd0;
        end else if (rob_bus.cdb_valid && rob_bus.cdb_rob_id == q) begin
            r = 1'b1; v = rob_bus.cdb_value;
        end else begin
            r = m_ready[q]; v = m_val[q];
        end
        check_eq({tag, "_ready"}, 32'(r_obs), 32'(r));
        if (r) check_eq({tag, "_value"}, v_obs, v);
    endtask

    task automatic check_comb();
        check_eq("rob_full", 32'(rob_bus.rob_full), 32'(mq.size() == N));
        check_eq("rob_id", 32'(rob_bus.rob_id_to_dispatcher), 32'(m_next_id));
        check_lookup("lookup1", rob_bus.Q1_from_dispatcher, rob_bus.ready1_to_dispatcher,
                     rob_bus.V1_to_dispatcher);
        check_lookup("lookup2", rob_bus.Q2_from_dispatcher, rob_bus.ready2_to_dispatcher,
                     rob_bus.V2_to_dispatcher);
    endtask

    task automatic check_regs();
        check_eq("commit_flag", 32'(rob_bus.commit_flag), 32'(e_commit));
        check_eq("rd_to_reg", 32'(rob_bus.rd_to_reg), 32'(e_rd));
        check_eq("Q_to_reg", 32'(rob_bus.Q_to_reg), 32'(e_q));
        check_eq("V_to_reg", rob_bus.V_to_reg, e_v);
        check_eq("rollback_flag", 32'(rob_bus.rollback_flag), 32'(e_rb));
        check_eq("target_pc", rob_bus.target_pc, e_tpc);
    endtask

    // One cycle: inputs are already applied (posedge+1); check, clock, check
    task automatic step();
        @(negedge clk_r);
        check_comb();
        model_edge();
        @(posedge clk_r);
        #1;
        check_regs();
    endtask

    task automatic set_idle();
        rob_bus.alloc_signal_from_dispatcher   = 1'b0;
        rob_bus.rd_from_dispatcher             = 5'd0;
        rob_bus.pc_from_dispatcher             = 32'd0;
        rob_bus.is_branch_from_dispatcher      = 1'b0;
        rob_bus.predicted_jump_from_dispatcher = 1'b0;
        rob_bus.Q1_from_dispatcher             = 5'd0;
        rob_bus.Q2_from_dispatcher             = 5'd0;
        rob_bus.cdb_valid                      = 1'b0;
        rob_bus.cdb_rob_id                     = 5'd0;
        rob_bus.cdb_value                      = 32'd0;
        rob_bus.cdb_jump                       = 1'b0;
        rob_bus.cdb_target_pc                  = 32'd0;
    endtask

    task automatic alloc_in(input logic [4:0] rd, input logic [31:0] pc, input logic br,
                            input logic pred);
        rob_bus.alloc_signal_from_dispatcher   = 1'b1;
        rob_bus.rd_from_dispatcher             = rd;
        rob_bus.pc_from_dispatcher             = pc;
        rob_bus.is_branch_from_dispatcher      = br;
        rob_bus.predicted_jump_from_dispatcher = pred;
    endtask

    task automatic cdb_in(input logic [4:0] id, input logic [31:0] val, input logic jmp,
                          input logic [31:0] tgt);
        rob_bus.cdb_valid     = 1'b1;
        rob_bus.cdb_rob_id    = id;
        rob_bus.cdb_value     = val;
        rob_bus.cdb_jump      = jmp;
        rob_bus.cdb_target_pc = tgt;
    endtask

    task automatic do_reset();
        set_idle();
        rdy_r = 1'b1;
        rst_r = 1'b0;
        #1;
        model_reset();
        check_eq("rst_commit", 32'(rob_bus.commit_flag), 32'd0);
        check_eq("rst_rob_id", 32'(rob_bus.rob_id_to_dispatcher), 32'd1);
        @(negedge clk_r);
        rst_r = 1'b1;
        @(posedge clk_r);
        #1;
    endtask

    initial begin
        int sel;
        rst_r = 1'b1;
        rdy_r = 1'b1;
        set_idle();
        #2;
        do_reset();
        check_regs();

        // Single allocate, complete, commit
        alloc_in(5'd5, 32'h40, 1'b0, 1'b0); step();
        set_idle(); cdb_in(5'd1, 32'h1234, 1'b0, 32'd0); step();
        check_eq("cdb_edge_no_commit", 32'(rob_bus.commit_flag), 32'd0);
        set_idle(); step();
        check_eq("basic_commit", 32'(rob_bus.commit_flag), 32'd1);
        check_eq("basic_rd", 32'(rob_bus.rd_to_reg), 32'd5);
        check_eq("basic_q", 32'(rob_bus.Q_to_reg), 32'd1);
        check_eq("basic_v", rob_bus.V_to_reg, 32'h1234);
        step();

        // Fill to full, ignored 17th allocation, commit, wrap
        do_reset();
        for (int i = 0; i < N; i++) begin
            alloc_in(5'(i + 1), 32'(i * 4), 1'b0, 1'b0); step();
        end
        check_eq("full_after_16", 32'(rob_bus.rob_full), 32'd1);
        alloc_in(5'd31, 32'h999, 1'b0, 1'b0); step();
        set_idle(); cdb_in(5'd1, 32'h77, 1'b0, 32'd0); step();
        set_idle(); step();
        check_eq("full_commit_q", 32'(rob_bus.Q_to_reg), 32'd1);
        check_eq("full_commit_rd", 32'(rob_bus.rd_to_reg), 32'd1);
        check_eq("not_full_after", 32'(rob_bus.rob_full), 32'd0);
        check_eq("wrap_id", 32'(rob_bus.rob_id_to_dispatcher), 32'd1);
        alloc_in(5'd9, 32'h500, 1'b0, 1'b0); step();
        set_idle(); step();

        // Out-of-order completion, in-order retire
        do_reset();
        for (int i = 0; i < 3; i++) begin
            alloc_in(5'(10 + i), 32'(i * 4), 1'b0, 1'b0); step();
        end
        for (int i = 3; i >= 1; i--) begin
            set_idle(); cdb_in(5'(i), 32'(100 + i), 1'b0, 32'd0); step();
            check_eq("ooo_no_early_commit", 32'(rob_bus.commit_flag), 32'd0);
        end
        set_idle();
        for (int i = 1; i <= 3; i++) begin
            step();
            check_eq("ooo_order_q", 32'(rob_bus.Q_to_reg), 32'(i));
            check_eq("ooo_order_v", rob_bus.V_to_reg, 32'(100 + i));
        end

        // Mispredicted branch flushes, same-cycle allocation dropped
        do_reset();
        alloc_in(5'd3, 32'h100, 1'b1, 1'b1); step();
        alloc_in(5'd4, 32'h104, 1'b0, 1'b0); step();
        set_idle(); cdb_in(5'd1, 32'd0, 1'b0, 32'h200); step();
        set_idle(); alloc_in(5'd6, 32'h108, 1'b0, 1'b0); step();
        check_eq("mp_commit", 32'(rob_bus.commit_flag), 32'd1);
        check_eq("mp_rollback", 32'(rob_bus.rollback_flag), 32'd1);
        check_eq("mp_target", rob_bus.target_pc, 32'h104);
        check_eq("mp_rob_id", 32'(rob_bus.rob_id_to_dispatcher), 32'd1);
        set_idle(); step();
        check_eq("mp_pulse_end", 32'(rob_bus.rollback_flag), 32'd0);

        // Same-cycle CDB bypass on lookup
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc_in(5'(i + 1), 32'(i * 4), 1'b0, 1'b0); step();
        end
        set_idle(); cdb_in(5'd4, 32'hAB, 1'b0, 32'd0);
        rob_bus.Q1_from_dispatcher = 5'd4;
        rob_bus.Q2_from_dispatcher = 5'd0;
        @(negedge clk_r);
        check_eq("bypass_ready1", 32'(rob_bus.ready1_to_dispatcher), 32'd1);
        check_eq("bypass_v1", rob_bus.V1_to_dispatcher, 32'hAB);
        check_eq("zero_ready2", 32'(rob_bus.ready2_to_dispatcher), 32'd1);
        check_eq("zero_v2", rob_bus.V2_to_dispatcher, 32'd0);
        model_edge();
        @(posedge clk_r); #1; check_regs();

        // Freeze with ready head, then resume; then mid-commit reset
        do_reset();
        alloc_in(5'd7, 32'h20, 1'b0, 1'b0); step();
        set_idle(); cdb_in(5'd1, 32'h55, 1'b0, 32'd0); step();
        set_idle(); rdy_r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("frozen_no_commit", 32'(rob_bus.commit_flag), 32'd0);
        end
        rdy_r = 1'b1; step();
        check_eq("resume_commit", 32'(rob_bus.commit_flag), 32'd1);
        alloc_in(5'd8, 32'h24, 1'b0, 1'b0); step();
        set_idle(); cdb_in(5'd2, 32'h66, 1'b0, 32'd0); step();
        set_idle(); step();
        check_eq("pre_reset_commit", 32'(rob_bus.commit_flag), 32'd1);
        rst_r = 1'b0; #1;
        check_eq("async_commit", 32'(rob_bus.commit_flag), 32'd0);
        check_eq("async_rd", 32'(rob_bus.rd_to_reg), 32'd0);
        check_eq("async_q", 32'(rob_bus.Q_to_reg), 32'd0);
        check_eq("async_v", rob_bus.V_to_reg, 32'd0);
        check_eq("async_tpc", rob_bus.target_pc, 32'd0);
        check_eq("async_rob_id", 32'(rob_bus.rob_id_to_dispatcher), 32'd1);
        check_eq("async_full", 32'(rob_bus.rob_full), 32'd0);
        model_reset();
        @(negedge clk_r); rst_r = 1'b1;
        @(posedge clk_r); #1;
        for (int i = 0; i < 3; i++) step();

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            set_idle();
            rdy_r = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) < 6) begin
                alloc_in(5'($urandom_range(0, 31)), $urandom & 32'hFFFF_FFFC,
                         ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 1) == 1) begin
                if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                    sel = $urandom_range(0, mq.size() - 1);
                    cdb_in(5'(mq[sel].id), $urandom,
                           ($urandom_range(0, 7) == 0) ? ~mq[sel].pred : mq[sel].pred,
                           $urandom & 32'hFFFF_FFFC);
                end else begin
                    cdb_in(5'($urandom_range(0, N)), $urandom, 1'($urandom_range(0, 1)), $urandom);
                end
            end
            rob_bus.Q1_from_dispatcher = 5'($urandom_range(0, N));
            rob_bus.Q2_from_dispatcher = 5'($urandom_range(0, N));
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
